// File: rtl/dpseq_pkg.sv
// Shared types, field layout and opcode constants for the datapath sequencer.
// Field layout of a program word, MSB to LSB: halt, fe, ri, opcode, dst, rd, rs, imm.
package dpseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b01001;
    localparam logic [4:0] OP_AND = 5'b00001;
    localparam logic [4:0] OP_OR  = 5'b00010;
    localparam logic [4:0] OP_XOR = 5'b00011;
    localparam logic [4:0] OP_NOT = 5'b00100;
    localparam logic [4:0] OP_LSH = 5'b01100;
    localparam logic [4:0] OP_RSH = 5'b10011;

    function automatic int word_w(input int data_w, input int reg_aw, input int opc_w);
        return 3 + opc_w + 3 * reg_aw + data_w;
    endfunction

    function automatic int rs_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int rd_lsb(input int data_w, input int reg_aw);
        return data_w + reg_aw;
    endfunction

    function automatic int dst_lsb(input int data_w, input int reg_aw);
        return data_w + 2 * reg_aw;
    endfunction

    function automatic int opc_lsb(input int data_w, input int reg_aw);
        return data_w + 3 * reg_aw;
    endfunction

    function automatic int ri_bit(input int data_w, input int reg_aw, input int opc_w);
        return data_w + 3 * reg_aw + opc_w;
    endfunction

    function automatic int fe_bit(input int data_w, input int reg_aw, input int opc_w);
        return data_w + 3 * reg_aw + opc_w + 1;
    endfunction

    function automatic int halt_bit(input int data_w, input int reg_aw, input int opc_w);
        return data_w + 3 * reg_aw + opc_w + 2;
    endfunction

endpackage

// File: rtl/dpseq_prog_ram.sv
// Program table: DEPTH x W, synchronous write, asynchronous read; contents are not reset.
module dpseq_prog_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 36,
    localparam int PC_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PC_W-1:0] waddr,
    input  logic [W-1:0]    wdata,
    input  logic [PC_W-1:0] raddr,
    output logic [W-1:0]    rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/datapath_sequencer.sv
// Loadable micro-op sequencer driving regfile/ALU control lines with start/done and stall.
// Optional DPSEQ_LOOP_EN adds loop_cnt: the program repeats loop_cnt+1 times.
module datapath_sequencer
    import dpseq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 16,
    parameter int DEPTH   = 16,
    parameter int OPC_W   = 5,
    localparam int REG_AW = $clog2(NREGS),
    localparam int PC_W   = $clog2(DEPTH),
    localparam int W      = word_w(DATA_W, REG_AW, OPC_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [W-1:0]      prog_wdata,
`ifdef DPSEQ_LOOP_EN
    input  logic [7:0]        loop_cnt,
`endif
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   pc,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rd,
    output logic [OPC_W-1:0]  opcode,
    output logic [NREGS-1:0]  re,
    output logic              ri,
    output logic              fe,
    output logic [DATA_W-1:0] imm
);

    localparam int RS_L  = rs_lsb(DATA_W);
    localparam int RD_L  = rd_lsb(DATA_W, REG_AW);
    localparam int DST_L = dst_lsb(DATA_W, REG_AW);
    localparam int OPC_L = opc_lsb(DATA_W, REG_AW);
    localparam int RI_B  = ri_bit(DATA_W, REG_AW, OPC_W);
    localparam int FE_B  = fe_bit(DATA_W, REG_AW, OPC_W);
    localparam int HLT_B = halt_bit(DATA_W, REG_AW, OPC_W);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [W-1:0]    word;
    logic            last;
`ifdef DPSEQ_LOOP_EN
    logic [7:0]      pass_q, pass_d;
`endif

    dpseq_prog_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
        .clk   (clk),
        .we    (prog_we && (state_q == ST_IDLE)),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc_q),
        .rdata (word)
    );

    // The final table entry acts as an implicit halt so pc never wraps.
    assign last = word[HLT_B] || (pc_q == PC_W'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef DPSEQ_LOOP_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
`ifdef DPSEQ_LOOP_EN
                    pass_d  = loop_cnt;
`endif
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (last) begin
`ifdef DPSEQ_LOOP_EN
                        if (pass_q != 8'd0) begin
                            pc_d   = '0;
                            pass_d = pass_q - 8'd1;
                        end else begin
                            state_d = ST_DONE;
                            pc_d    = '0;
                        end
`else
                        state_d = ST_DONE;
                        pc_d    = '0;
`endif
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
`ifdef DPSEQ_LOOP_EN
            pass_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef DPSEQ_LOOP_EN
            pass_q  <= pass_d;
`endif
        end
    end

    // Control lines decode the current entry combinationally so each entry lands in its own cycle.
    always_comb begin
        rs     = '0;
        rd     = '0;
        opcode = '0;
        re     = '0;
        ri     = 1'b0;
        fe     = 1'b0;
        imm    = '0;
        if (state_q == ST_RUN) begin
            rs     = word[RS_L +: REG_AW];
            rd     = word[RD_L +: REG_AW];
            opcode = word[OPC_L +: OPC_W];
            ri     = word[RI_B];
            imm    = word[DATA_W-1:0];
            if (!stall) begin
                re = NREGS'(1) << word[DST_L +: REG_AW];
                fe = word[FE_B];
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign pc   = pc_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized self-checking bench: a cycle-trace model of each program run is built from the
// program contents, then replayed against the sequencer one cycle at a time.
module tb_datapath_sequencer;
    import dpseq_pkg::*;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic       halt;
        logic       fe;
        logic       ri;
        logic [4:0] opc;
        logic [3:0] dst;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [15:0] imm;
    } word_t;

    typedef struct {
        bit          stall;
        bit          busy;
        bit          done;
        logic [3:0]  pc;
        logic [46:0] ctl;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [35:0] prog_wdata = '0;
`ifdef DPSEQ_LOOP_EN
    logic [7:0]  loop_cnt = '0;
`endif
    logic        busy, done, ri, fe;
    logic [3:0]  pc, rs, rd;
    logic [4:0]  opcode;
    logic [15:0] re, imm;

    word_t prog_m [DEPTH];
    int errors = 0;
    int checks = 0;

    datapath_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata),
`ifdef DPSEQ_LOOP_EN
        .loop_cnt(loop_cnt),
`endif
        .busy(busy), .done(done), .pc(pc), .rs(rs), .rd(rd), .opcode(opcode),
        .re(re), .ri(ri), .fe(fe), .imm(imm)
    );

    always #5 clk = ~clk;

    function automatic logic [46:0] ctl_of(input word_t e, input bit stalled);
        logic [15:0] onehot;
        onehot = '0;
        if (!stalled) onehot[e.dst] = 1'b1;
        return {e.rs, e.rd, e.opc, onehot, e.ri, e.fe & ~stalled, e.imm};
    endfunction

    function automatic word_t mk(input logic [4:0] opc, input int dst_i, input int rd_i,
                                 input int rs_i, input bit ri_i, input int imm_i, input bit h);
        word_t w;
        w = '0;
        w.opc = opc; w.dst = 4'(dst_i); w.rd = 4'(rd_i); w.rs = 4'(rs_i);
        w.ri = ri_i; w.imm = 16'(imm_i); w.halt = h;
        return w;
    endfunction

    function automatic word_t rnd_word(input int halt_pct);
        logic [35:0] t;
        word_t w;
        t = 36'({$urandom(), $urandom()});
        w = t;
        w.halt = ($urandom_range(0, 99) < halt_pct);
        return w;
    endfunction

    task automatic load(input int a, input word_t w);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'(a); prog_wdata = w;
        @(negedge clk);
        prog_we = 1'b0;
        prog_m[a] = w;
    endtask

    // Expected trace: each entry executes once per pass, preceded by any stall cycles,
    // until a halt or the last table slot; then one DONE cycle and a return to idle.
    task automatic run_prog(input string name, input int stall_pc, input int stall_len,
                            input bit rnd_stall, input bit poke, input int loops);
        rec_t q[$];
        rec_t r;
        logic [46:0] got;
        for (int pass = 0; pass <= loops; pass++) begin
            for (int p = 0; p < DEPTH; p++) begin
                int ns;
                ns = (pass == 0 && p == stall_pc) ? stall_len :
                     (rnd_stall ? int'($urandom_range(0, 3) == 0) : 0);
                for (int s = 0; s < ns; s++)
                    q.push_back('{1'b1, 1'b1, 1'b0, 4'(p), ctl_of(prog_m[p], 1'b1)});
                q.push_back('{1'b0, 1'b1, 1'b0, 4'(p), ctl_of(prog_m[p], 1'b0)});
                if (prog_m[p].halt) break;
            end
        end
        q.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 47'd0});
        q.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 47'd0});

        @(negedge clk);
        start = 1'b1;
`ifdef DPSEQ_LOOP_EN
        loop_cnt = 8'(loops);
`endif
        @(negedge clk);
        start = 1'b0;
        foreach (q[i]) begin
            r = q[i];
            stall = r.stall;
            start = poke && (r.busy || r.done);
            prog_we = start;
            prog_addr = '0;
            prog_wdata = '0;
            #1;
            got = {rs, rd, opcode, re, ri, fe, imm};
            checks++;
            if ({busy, done} !== {r.busy, r.done}) begin
                errors++;
                $display("FAIL %s busy/done cyc %0d: got %b%b want %b%b", name, i + 1, busy, done, r.busy, r.done);
            end
            checks++;
            if (pc !== r.pc) begin
                errors++;
                $display("FAIL %s pc cyc %0d: got %0d want %0d", name, i + 1, pc, r.pc);
            end
            checks++;
            if (got !== r.ctl) begin
                errors++;
                $display("FAIL %s ctl cyc %0d: got %h want %h", name, i + 1, got, r.ctl);
            end
            @(negedge clk);
        end
        stall = 1'b0; start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({busy, done, pc, rs, rd, opcode, re, ri, fe, imm} !== 58'd0) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b pc=%0d re=%h ctl=%h want all 0", name,
                     busy, done, pc, re, {rs, rd, opcode, ri, fe, imm});
        end
    endtask

    task automatic test_reset();
        #1;
        check_quiet("reset_outputs");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_quiet("idle_after_reset");
    endtask

    task automatic load_fib();
        load(0, mk(OP_ADD, 1, 0, 0, 1'b1, 1, 1'b0));
        load(1, mk(OP_ADD, 2, 1, 0, 1'b0, 0, 1'b0));
        load(2, mk(OP_ADD, 3, 2, 1, 1'b0, 0, 1'b1));
    endtask

    task automatic test_fibonacci();
        load_fib();
        run_prog("fib", -1, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_stall();
        run_prog("stall", 1, 2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_full_table();
        for (int a = 0; a < DEPTH; a++) load(a, rnd_word(0));
        run_prog("full_table", -1, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_ignored_inputs();
        load_fib();
        run_prog("ignored_run", -1, 0, 1'b0, 1'b1, 0);
        run_prog("ignored_rerun", -1, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_mid_reset();
        load_fib();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (pc !== 4'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre: got pc=%0d busy=%b want pc=1 busy=1", pc, busy);
        end
        rst = 1'b0;
        #1;
        check_quiet("mid_reset_async");
        @(negedge clk);
        rst = 1'b1;
        run_prog("after_reset", -1, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            for (int a = 0; a < DEPTH; a++) load(a, rnd_word(20));
            run_prog("random", int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b1, 1'b0, 0);
        end
    endtask

`ifdef DPSEQ_LOOP_EN
    task automatic test_loop();
        load_fib();
        run_prog("loop", -1, 0, 1'b0, 1'b0, 2);
        for (int a = 0; a < DEPTH; a++) load(a, rnd_word(25));
        run_prog("loop_rand", -1, 0, 1'b1, 1'b0, int'($urandom_range(1, 3)));
    endtask
`endif

    initial begin
        test_reset();
        test_fibonacci();
        test_stall();
        test_full_table();
        test_ignored_inputs();
        test_mid_reset();
        test_random();
`ifdef DPSEQ_LOOP_EN
        test_loop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
